// File: rtl/ysyx_22050854_opnd_stage.sv
// ysyx_22050854_opnd_stage
// Registered ALU operand stage: selects src1/src2, resolves register operands
// against forwarding channels (channel 0 youngest), stalls on pending producers
// and hands operands to execute through a one-entry valid/ready register.
module ysyx_22050854_opnd_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 32,
    parameter int NFWD = 3,
    parameter int INC  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic                 in_src1_sel,
    input  logic [1:0]           in_src2_sel,
    input  logic                 in_store,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_src1,
    output logic [XLEN-1:0]      out_src2,
    output logic [XLEN-1:0]      out_sdata,
    output logic [31:0]          stall_cnt
);

    localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

    // Returns {pending, value} for one register operand. The first matching
    // channel wins so an older pending write hidden behind a younger ready one
    // cannot stall us. x0 is hardwired to zero and never hazards.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]           rs,
        input logic [XLEN-1:0]      rf,
        input logic [NFWD-1:0]      v,
        input logic [NFWD-1:0]      p,
        input logic [5*NFWD-1:0]    rd,
        input logic [XLEN*NFWD-1:0] d
    );
        logic [XLEN:0] r;
        logic          hit;
        r   = {1'b0, rf};
        hit = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (!hit && v[i] && (rd[5*i +: 5] == rs)) begin
                hit = 1'b1;
                r   = {p[i], d[XLEN*i +: XLEN]};
            end
        end
        if (rs == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

    logic [XLEN:0]   rs1_res;
    logic [XLEN:0]   rs2_res;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            use_rs1;
    logic            use_rs2;
    logic            hazard;
    logic            capture;
    logic [XLEN-1:0] src1_next;
    logic [XLEN-1:0] src2_next;
    logic [XLEN-1:0] sdata_next;

    // Forwarding, hazard detection and the handshake that decides acceptance.
    always_comb begin
        rs1_res  = resolve(in_rs1, in_rs1_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);
        rs2_res  = resolve(in_rs2, in_rs2_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);
        rs1_val  = rs1_res[XLEN-1:0];
        rs2_val  = rs2_res[XLEN-1:0];
        use_rs1  = !in_src1_sel;
        use_rs2  = (in_src2_sel == 2'b00) || in_store;
        hazard   = in_valid && ((use_rs1 && rs1_res[XLEN]) || (use_rs2 && rs2_res[XLEN]));
        in_ready = !hazard && (!out_valid || out_ready) && !flush;
        capture  = in_valid && in_ready;
    end

    // Operand muxes feeding the output register.
    always_comb begin
        src1_next = in_src1_sel ? XLEN'(in_pc) : rs1_val;
        unique case (in_src2_sel)
            2'b00:   src2_next = rs2_val;
            2'b01:   src2_next = in_imm;
            2'b10:   src2_next = INC_X;
            default: src2_next = '0;
        endcase
        sdata_next = in_store ? rs2_val : '0;
    end

    // One-entry output register; flush drops the held entry and blocks capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_sdata <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_src1  <= src1_next;
            out_src2  <= src2_next;
            out_sdata <= sdata_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to operand hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/ysyx_22050854_opnd_stage.md
# ysyx_22050854_opnd_stage

Registered ALU operand stage that replaces the purely combinational operand select between decode and execute. It selects ALU source 1 and source 2 (register, PC, immediate, increment constant, zero), resolves register operands against a parametrised set of forwarding channels, and stalls on data that is not yet produced (load-use). Operands leave through a one-entry valid/ready output register, so decode and execute are decoupled by one cycle.

## Interface
- XLEN, 64, datapath width
- PC_W, 32, PC width; zero-extended to XLEN
- NFWD, 3, number of forwarding channels; channel 0 is the youngest producer
- INC, 4, constant driven for src2_sel = 2'b10
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  PC_W  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2  in  5 each  source register indices
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
- in_src1_sel  in  1  0: rs1, 1: PC
- in_src2_sel  in  2  00: rs2, 01: imm, 10: INC, 11: zero
- in_store  in  1  instruction needs rs2 as store data
- fwd_valid  in  NFWD  channel carries a register write
- fwd_pending  in  NFWD  channel's value not yet available
- fwd_rd  in  5*NFWD  destination index, channel i at [5i+4:5i]
- fwd_data  in  XLEN*NFWD  value, channel i at [XLEN*i+XLEN-1:XLEN*i]
- flush  in  1  kill the held entry and any capture this cycle
- out_valid  out  1  operands valid
- out_ready  in  1  execute consumes
- out_src1, out_src2  out  XLEN each  ALU operands
- out_sdata  out  XLEN  forwarded rs2 value for stores
- stall_cnt  out  32  cycles stalled on hazards, saturating

## Operation
- Forwarding per operand (rs1, rs2): scan channels 0..NFWD-1; first i with fwd_valid[i] and fwd_rd[i] equals rs gives the value; no match uses the register-file data. rs = 0 never matches; value is 0 regardless of inputs.
- rs1 used iff in_src1_sel = 0. rs2 used iff in_src2_sel = 00 or in_store = 1. Unused operands never cause a hazard.
- hazard = in_valid and some used operand's first matching channel has fwd_pending = 1. A pending channel behind a younger non-pending match is ignored.
- Operand mux: src1 = sel ? {zeros, in_pc} : fwd rs1. src2 per in_src2_sel, with INC zero-extended to XLEN. out_sdata = forwarded rs2 (zero if in_store = 0).
- in_ready = !hazard and (!out_valid or out_ready) and !flush.
- Capture = in_valid and in_ready: load out_src1/out_src2/out_sdata, out_valid <= 1.
- Consume without capture: out_valid <= 0; data registers keep their value.
- flush: out_valid <= 0 next edge; no capture that cycle; takes priority over everything except rst.
- stall_cnt increments when in_valid and hazard and !flush; saturates at 2^32-1.

## Timing
- Reset: out_valid = 0, out_src1 = out_src2 = out_sdata = 0, stall_cnt = 0. in_ready follows its equation (combinational).
- Latency: accepted at edge N, visible on outputs after edge N; out_valid high from cycle N+1.
- Full throughput: out_valid and out_ready both high with a new capture in the same cycle gives back-to-back transfer with no bubble.
- Backpressure: out_valid and !out_ready -> in_ready = 0; out registers stable until consumed.
- Hazard resolves (fwd_pending drops) in cycle M: capture at edge M with the forwarded value from that cycle.
- in_ready is combinational from fwd_* and out_ready. No combinational path from in_* to out_*.
- rst mid-transfer discards the held entry; stall_cnt restarts from 0.

## Test plan
- After rst: out_valid = 0, stall_cnt = 0. Drive in_src1_sel = 1, in_pc = 0x80000000, in_src2_sel = 10. One cycle later: out_src1 = 0x0000000080000000, out_src2 = 4.
- Drive rs1 = 5, rf data 0x11, channel 2 rd = 5 data 0x22, channel 0 rd = 5 data 0x33, all valid. Expect out_src1 = 0x33. With rs1 = 0 and a channel rd = 0 carrying 0x44, expect out_src1 = 0.
- Load-use: channel 0 rd = 7 pending for 3 cycles, rs2 = 7, in_src2_sel = 00. Expect in_ready = 0 for 3 cycles and stall_cnt = 3. Pending drops with data 0x55: out_src2 = 0x55 one cycle later. Same case with in_src2_sel = 01 and in_store = 0: no stall.
- Backpressure: stream 4 instructions with out_ready low for 2 cycles mid-stream. No loss or duplication, order preserved; with out_ready high, one transfer per cycle.
- flush while out_valid = 1 and in_valid = 1: next cycle out_valid = 0 and the flushed input is not captured. The following instruction is accepted normally.
